// File: rtl/sequenciador_banco_pkg.sv
// Shared types for the register-bank sequencer.
// Verify states exist only when WRITE_VERIFY_EN is defined.
package pkg_banco;

  localparam int DW = 32;

  typedef enum logic [1:0] {
    OP_WRITE     = 2'b00,
    OP_READ_PAIR = 2'b01,
    OP_READ_ONE  = 2'b10,
    OP_RSVD      = 2'b11
  } op_t;

  typedef enum logic [1:0] {
    REG_A    = 2'b00,
    REG_B    = 2'b01,
    REG_ACC  = 2'b10,
    REG_ZERO = 2'b11
  } reg_t;

`ifdef WRITE_VERIFY_EN
  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ESCRITA   = 3'd1,
    ST_LEITURA   = 3'd2,
    ST_CAPTURA   = 3'd3,
    ST_RESP      = 3'd4,
    ST_VERIF_RD  = 3'd5,
    ST_VERIF_CAP = 3'd6
  } state_t;
`else
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ESCRITA = 3'd1,
    ST_LEITURA = 3'd2,
    ST_CAPTURA = 3'd3,
    ST_RESP    = 3'd4
  } state_t;
`endif

endpackage

// File: rtl/sequenciador_banco.sv
// Command sequencer driving a falling-edge-write register bank.
// WRITE_VERIFY_EN adds a read-back check after every write.
module sequenciador_banco
  import pkg_banco::*;
(
  input  logic          Clock,
  input  logic          Reset_n,
  input  logic          Cmd_valid,
  output logic          Cmd_ready,
  input  logic [1:0]    Cmd_op,
  input  logic [1:0]    Cmd_reg,
  input  logic [1:0]    Cmd_reg2,
  input  logic [DW-1:0] Cmd_dado,
  output logic [1:0]    IdReg,
  output logic [1:0]    Fonte1,
  output logic [1:0]    Fonte2,
  output logic          Escrita,
  output logic          Flag_mem,
  output logic [DW-1:0] Dado,
  input  logic [DW-1:0] DadoLido1,
  input  logic [DW-1:0] DadoLido2,
  output logic          Resp_valid,
  input  logic          Resp_ready,
  output logic [DW-1:0] Resp_dado1,
  output logic [DW-1:0] Resp_dado2,
  output logic          Resp_erro
);

  state_t        state, state_nx;
  logic          erro_pend, erro_pend_nx;
  logic          cmd_ready_nx;
  logic          escrita_nx, flag_nx;
  logic [1:0]    idreg_nx, fonte1_nx, fonte2_nx;
  logic [DW-1:0] dado_nx, dado1_nx, dado2_nx;
  logic          resp_valid_nx, resp_erro_nx;
  logic          accept, wr_ok, rd_pair, rd_one, bad;

  assign accept  = Cmd_valid && Cmd_ready;
  assign wr_ok   = (Cmd_op == OP_WRITE) &&
                   (Cmd_reg != REG_ZERO);
  assign rd_pair = (Cmd_op == OP_READ_PAIR);
  assign rd_one  = (Cmd_op == OP_READ_ONE);
  assign bad     = !(wr_ok || rd_pair || rd_one);

  // Next state and next registered outputs.
  always_comb begin
    state_nx      = state;
    erro_pend_nx  = erro_pend;
    cmd_ready_nx  = Cmd_ready;
    escrita_nx    = Escrita;
    flag_nx       = Flag_mem;
    idreg_nx      = IdReg;
    fonte1_nx     = Fonte1;
    fonte2_nx     = Fonte2;
    dado_nx       = Dado;
    dado1_nx      = Resp_dado1;
    dado2_nx      = Resp_dado2;
    resp_valid_nx = Resp_valid;
    resp_erro_nx  = Resp_erro;
    unique case (state)
      ST_IDLE: begin
        cmd_ready_nx = 1'b1;
        escrita_nx   = 1'b0;
        flag_nx      = 1'b0;
        if (accept) begin
          cmd_ready_nx = 1'b0;
          unique case (1'b1)
            wr_ok: begin
              state_nx     = ST_ESCRITA;
              escrita_nx   = 1'b1;
              idreg_nx     = Cmd_reg;
              dado_nx      = Cmd_dado;
              erro_pend_nx = 1'b0;
            end
            rd_pair: begin
              state_nx  = ST_LEITURA;
              fonte1_nx = REG_ACC;
              fonte2_nx = Cmd_reg2;
            end
            rd_one: begin
              state_nx  = ST_LEITURA;
              flag_nx   = 1'b1;
              fonte1_nx = Cmd_reg;
            end
            bad: begin
              // Reuse the one-cycle slot, bank untouched.
              state_nx     = ST_ESCRITA;
              erro_pend_nx = 1'b1;
            end
            default: ;
          endcase
        end
      end
      ST_ESCRITA: begin
        escrita_nx = 1'b0;
`ifdef WRITE_VERIFY_EN
        if (erro_pend) begin
          state_nx      = ST_RESP;
          resp_valid_nx = 1'b1;
          resp_erro_nx  = 1'b1;
          dado1_nx      = '0;
          dado2_nx      = '0;
        end else begin
          state_nx  = ST_VERIF_RD;
          flag_nx   = 1'b1;
          fonte1_nx = IdReg;
        end
`else
        state_nx      = ST_RESP;
        resp_valid_nx = 1'b1;
        resp_erro_nx  = erro_pend;
        dado1_nx      = '0;
        dado2_nx      = '0;
`endif
      end
      ST_LEITURA: state_nx = ST_CAPTURA;
      ST_CAPTURA: begin
        state_nx      = ST_RESP;
        resp_valid_nx = 1'b1;
        resp_erro_nx  = 1'b0;
        dado1_nx      = DadoLido1;
        dado2_nx      = Flag_mem ? '0 : DadoLido2;
        flag_nx       = 1'b0;
      end
`ifdef WRITE_VERIFY_EN
      ST_VERIF_RD: state_nx = ST_VERIF_CAP;
      ST_VERIF_CAP: begin
        state_nx      = ST_RESP;
        resp_valid_nx = 1'b1;
        resp_erro_nx  = (DadoLido1 != Dado);
        dado1_nx      = DadoLido1;
        dado2_nx      = '0;
        flag_nx       = 1'b0;
      end
`endif
      ST_RESP: begin
        if (Resp_ready) begin
          state_nx      = ST_IDLE;
          resp_valid_nx = 1'b0;
          cmd_ready_nx  = 1'b1;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // State and output registers; reset aborts any bank access.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state      <= ST_IDLE;
      erro_pend  <= 1'b0;
      Cmd_ready  <= 1'b0;
      Escrita    <= 1'b0;
      Flag_mem   <= 1'b0;
      IdReg      <= '0;
      Fonte1     <= '0;
      Fonte2     <= '0;
      Dado       <= '0;
      Resp_dado1 <= '0;
      Resp_dado2 <= '0;
      Resp_valid <= 1'b0;
      Resp_erro  <= 1'b0;
    end else begin
      state      <= state_nx;
      erro_pend  <= erro_pend_nx;
      Cmd_ready  <= cmd_ready_nx;
      Escrita    <= escrita_nx;
      Flag_mem   <= flag_nx;
      IdReg      <= idreg_nx;
      Fonte1     <= fonte1_nx;
      Fonte2     <= fonte2_nx;
      Dado       <= dado_nx;
      Resp_dado1 <= dado1_nx;
      Resp_dado2 <= dado2_nx;
      Resp_valid <= resp_valid_nx;
      Resp_erro  <= resp_erro_nx;
    end
  end

endmodule

// File: tb/tb_sequenciador_banco.sv
// Bench for sequenciador_banco with a falling-edge bank model.
// Define WRITE_VERIFY_EN to check the read-back variant.
module tb_sequenciador_banco;

  logic        Clock = 1'b0;
  logic        Reset_n = 1'b0;
  logic        Cmd_valid = 1'b0;
  logic        Cmd_ready;
  logic [1:0]  Cmd_op = '0;
  logic [1:0]  Cmd_reg = '0;
  logic [1:0]  Cmd_reg2 = '0;
  logic [31:0] Cmd_dado = '0;
  logic [1:0]  IdReg, Fonte1, Fonte2;
  logic        Escrita, Flag_mem;
  logic [31:0] Dado, DadoLido1, DadoLido2;
  logic        Resp_valid;
  logic        Resp_ready = 1'b0;
  logic [31:0] Resp_dado1, Resp_dado2;
  logic        Resp_erro;

  int checks = 0;
  int passes = 0;

`ifdef WRITE_VERIFY_EN
  localparam int WR_LAT = 3;
  localparam bit VERIFY = 1'b1;
`else
  localparam int WR_LAT = 1;
  localparam bit VERIFY = 1'b0;
`endif

  sequenciador_banco dut (
    .Clock(Clock), .Reset_n(Reset_n),
    .Cmd_valid(Cmd_valid), .Cmd_ready(Cmd_ready),
    .Cmd_op(Cmd_op), .Cmd_reg(Cmd_reg),
    .Cmd_reg2(Cmd_reg2), .Cmd_dado(Cmd_dado),
    .IdReg(IdReg), .Fonte1(Fonte1), .Fonte2(Fonte2),
    .Escrita(Escrita), .Flag_mem(Flag_mem),
    .Dado(Dado), .DadoLido1(DadoLido1),
    .DadoLido2(DadoLido2), .Resp_valid(Resp_valid),
    .Resp_ready(Resp_ready), .Resp_dado1(Resp_dado1),
    .Resp_dado2(Resp_dado2), .Resp_erro(Resp_erro)
  );

  always #5 Clock = ~Clock;

  // Register bank: falling-edge write, zero register reads 0.
  logic [31:0] bank [0:3];
  initial for (int i = 0; i < 4; i++) bank[i] = '0;
  always @(negedge Clock)
    if (Escrita && IdReg != 2'd3) bank[IdReg] = Dado;
  assign DadoLido1 = Flag_mem ? bank[Fonte1] : bank[2];
  assign DadoLido2 = bank[Fonte2];

  task automatic chk(input string nm,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("FAIL %s got=%h want=%h", nm, got, exp);
  endtask

  // Transaction-level reference: per command, expected
  // latency and response; architectural register contents.
  logic [31:0] mregs [0:3];
  initial for (int i = 0; i < 4; i++) mregs[i] = '0;
  bit          m_ready, m_valid, m_wr, m_pend, m_pwr;
  int          m_rem;
  logic [1:0]  m_preg;
  logic [31:0] m_pdat, m_d1, m_d2;
  bit          m_er;

  always @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      m_ready = 0; m_valid = 0; m_wr = 0; m_pend = 0;
    end else begin
      m_wr = 0;
      if (m_valid) begin
        if (Resp_ready) begin
          m_valid = 0;
          m_ready = 1;
        end
      end else if (m_pend) begin
        m_rem--;
        if (m_rem == 0) begin
          m_pend  = 0;
          m_valid = 1;
          if (m_pwr) mregs[m_preg] = m_pdat;
        end
      end else if (!m_ready) begin
        m_ready = 1;
      end else if (Cmd_valid) begin
        m_ready = 0;
        m_pend  = 1;
        m_pwr   = 0;
        m_d1 = '0; m_d2 = '0; m_er = 0;
        if (Cmd_op == 2'd0 && Cmd_reg != 2'd3) begin
          m_pwr  = 1;
          m_wr   = 1;
          m_preg = Cmd_reg;
          m_pdat = Cmd_dado;
          m_rem  = WR_LAT;
          if (VERIFY) m_d1 = Cmd_dado;
        end else if (Cmd_op == 2'd1) begin
          m_d1  = mregs[2];
          m_d2  = mregs[Cmd_reg2];
          m_rem = 2;
        end else if (Cmd_op == 2'd2) begin
          m_d1  = mregs[Cmd_reg];
          m_rem = 2;
        end else begin
          m_er  = 1;
          m_rem = 1;
        end
      end
    end
  end

  // Per-cycle comparison against the reference.
  always @(negedge Clock) begin
    if (Reset_n) begin
      chk("cmd_ready", 32'(Cmd_ready), 32'(m_ready));
      chk("resp_valid", 32'(Resp_valid), 32'(m_valid));
      chk("escrita", 32'(Escrita), 32'(m_wr));
      if (m_valid) begin
        chk("resp_dado1", Resp_dado1, m_d1);
        chk("resp_dado2", Resp_dado2, m_d2);
        chk("resp_erro", 32'(Resp_erro), 32'(m_er));
      end
    end
  end

  task automatic do_cmd(input logic [1:0] op,
                        input logic [1:0] r,
                        input logic [1:0] r2,
                        input logic [31:0] d,
                        input int stall,
                        input bit poke,
                        output logic [31:0] d1,
                        output logic [31:0] d2,
                        output logic er,
                        output int lat,
                        output bit saw_wr);
    int n;
    @(negedge Clock);
    n = 0;
    while (!Cmd_ready && n < 50) begin
      @(negedge Clock);
      n++;
    end
    if (n >= 50) chk("ready_timeout", 32'(Cmd_ready), 1);
    Cmd_valid = 1; Cmd_op = op; Cmd_reg = r;
    Cmd_reg2 = r2; Cmd_dado = d;
    @(posedge Clock);
    @(negedge Clock);
    Cmd_valid = 0;
    Cmd_op = 2'($urandom); Cmd_reg = 2'($urandom);
    Cmd_reg2 = 2'($urandom); Cmd_dado = $urandom;
    saw_wr = Escrita;
    lat = 0;
    while (!Resp_valid && lat < 20) begin
      @(negedge Clock);
      lat++;
      if (Escrita) saw_wr = 1;
    end
    if (lat >= 20) chk("resp_timeout", 32'(Resp_valid), 1);
    for (int i = 0; i < stall; i++) begin
      if (poke) begin
        Cmd_valid = 1; Cmd_op = 2'd2;
        chk("hold_ready", 32'(Cmd_ready), 0);
        chk("hold_valid", 32'(Resp_valid), 1);
      end
      @(negedge Clock);
    end
    d1 = Resp_dado1; d2 = Resp_dado2; er = Resp_erro;
    Cmd_valid = 0;
    Resp_ready = 1;
    @(negedge Clock);
    Resp_ready = 0;
  endtask

  logic [31:0] d1, d2;
  logic        er;
  int          lat;
  bit          sw;

  initial begin
    #2;
    chk("rst_cmd_ready", 32'(Cmd_ready), 0);
    chk("rst_escrita", 32'(Escrita), 0);
    chk("rst_flag_mem", 32'(Flag_mem), 0);
    chk("rst_idreg", 32'(IdReg), 0);
    chk("rst_fonte1", 32'(Fonte1), 0);
    chk("rst_fonte2", 32'(Fonte2), 0);
    chk("rst_dado", Dado, 0);
    chk("rst_resp_valid", 32'(Resp_valid), 0);
    chk("rst_resp_erro", 32'(Resp_erro), 0);
    chk("rst_resp_dado1", Resp_dado1, 0);
    chk("rst_resp_dado2", Resp_dado2, 0);
    repeat (2) @(negedge Clock);
    #1 Reset_n = 1;

    do_cmd(2'd0, 2'd0, 2'd0, 32'h5, 0, 0,
           d1, d2, er, lat, sw);
    chk("wrA_lat", lat, WR_LAT);
    chk("wrA_erro", 32'(er), 0);
    chk("wrA_escrita", 32'(sw), 1);
    do_cmd(2'd2, 2'd0, 2'd0, 32'h0, 1, 0,
           d1, d2, er, lat, sw);
    chk("rdA_d1", d1, 32'h5);
    chk("rdA_d2", d2, 32'h0);
    chk("rdA_erro", 32'(er), 0);
    chk("rdA_lat", lat, 2);

    do_cmd(2'd0, 2'd2, 2'd0, 32'h1234_5678, 0, 0,
           d1, d2, er, lat, sw);
    do_cmd(2'd0, 2'd1, 2'd0, 32'hA, 2, 0,
           d1, d2, er, lat, sw);
    do_cmd(2'd1, 2'd3, 2'd1, 32'h0, 0, 0,
           d1, d2, er, lat, sw);
    chk("pair_d1", d1, 32'h1234_5678);
    chk("pair_d2", d2, 32'hA);
    chk("pair_lat", lat, 2);

    do_cmd(2'd0, 2'd3, 2'd0, 32'hCAFE, 0, 0,
           d1, d2, er, lat, sw);
    chk("wrZ_erro", 32'(er), 1);
    chk("wrZ_escrita", 32'(sw), 0);
    chk("wrZ_lat", lat, 1);
    do_cmd(2'd3, 2'd0, 2'd0, 32'hBEEF, 0, 0,
           d1, d2, er, lat, sw);
    chk("op3_erro", 32'(er), 1);
    chk("op3_escrita", 32'(sw), 0);
    chk("op3_lat", lat, 1);

    do_cmd(2'd2, 2'd1, 2'd0, 32'h0, 5, 1,
           d1, d2, er, lat, sw);
    chk("hold_d1", d1, 32'hA);
    chk("hold_erro", 32'(er), 0);

    @(negedge Clock);
    while (!Cmd_ready) @(negedge Clock);
    Cmd_valid = 1; Cmd_op = 2'd0; Cmd_reg = 2'd0;
    Cmd_dado = 32'hDEAD_BEEF;
    @(posedge Clock);
    #1 Reset_n = 0;
    #1;
    chk("abort_escrita", 32'(Escrita), 0);
    chk("abort_ready", 32'(Cmd_ready), 0);
    Cmd_valid = 0;
    repeat (2) @(negedge Clock);
    #1 Reset_n = 1;
    do_cmd(2'd2, 2'd0, 2'd0, 32'h0, 0, 0,
           d1, d2, er, lat, sw);
    chk("abort_rdA", d1, 32'h5);

    do_cmd(2'd0, 2'd1, 2'd0, 32'hFFFF_FFFF, 0, 0,
           d1, d2, er, lat, sw);
    chk("wrB_lat", lat, WR_LAT);
    chk("wrB_erro", 32'(er), 0);
    chk("wrB_d1", d1, VERIFY ? 32'hFFFF_FFFF : 32'h0);

    for (int i = 0; i < 60; i++)
      do_cmd(2'($urandom), 2'($urandom),
             2'($urandom), $urandom,
             $urandom_range(0, 3), 0,
             d1, d2, er, lat, sw);

    repeat (3) @(negedge Clock);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
